ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of the single-port synchronous RAM.
//  Shares the RAM between requester A (instruction/program fetch) and requester B (data/tape access).
//  Latches one request per grant, drives the RAM pins, captures read data and returns a one-cycle Ack.
//  Sits between the core sequencers and the RAM instance; the only master of the RAM pins.
// PARAMETERS
//  AddressSize  16  RAM address width (bits)
//  DataSize     10  RAM word width (bits)
// PORTS
//  Clk          in   1            single system clock, all state on posedge
//  Rst_n        in   1            asynchronous active-low reset
//  A_Req        in   1            A request; held high until A_Ack seen
//  A_WE_n       in   1            A: 0=write, 1=read
//  A_Addr       in   AddressSize  A address
//  A_WrData     in   DataSize     A write data
//  A_Ack        out  1            A one-cycle completion pulse
//  A_RdData     out  DataSize     A read data, valid with A_Ack, held until next A read completes
//  B_Req, B_WE_n, B_Addr, B_WrData, B_Ack, B_RdData   same as A, for requester B
//  Ram_Address  out  AddressSize  to RAM Address
//  Ram_In       out  DataSize     to RAM In
//  Ram_Out      in   DataSize     from RAM Out
//  Ram_CS       out  1            to RAM CS
//  Ram_WE_n     out  1            to RAM WE_n
//  Busy         out  1            1 when state != IDLE
// BEHAVIOUR
//  Reset (async, Rst_n=0): state=IDLE, Ptr=A, A_Ack=B_Ack=0, A_RdData=B_RdData=0, Ram_CS=0,
//   Ram_WE_n=1, Ram_Address=0, Ram_In=0, latched Grant/Addr/Data/WE cleared. Outputs change immediately.
//  States: IDLE -> ACCESS -> CAPTURE -> IDLE, one cycle each; no other transitions.
//  IDLE: eligible = Req & ~Ack (a requester whose Ack is high this cycle is masked).
//   None eligible: stay IDLE. One eligible: grant it. Both: grant Ptr side.
//   On grant edge: latch Grant, Addr, WrData, WE_n of winner; Ptr <= other requester; -> ACCESS.
//  ACCESS: Ram_CS=1, Ram_Address/Ram_In from latches, Ram_WE_n=latched WE_n; RAM acts on next edge.
//  CAPTURE: Ram_CS=1, Ram_Address held, Ram_WE_n=1 (read-back is harmless).
//   On exit edge: granted Ack<=1 for exactly one cycle; for reads granted RdData<=Ram_Out;
//   for writes RdData unchanged; -> IDLE.
//  IDLE/ACCESS-read/CAPTURE: Ram_WE_n=1. Ram_WE_n=0 only in ACCESS of a write grant (exactly 1 cycle).
//  Ram_CS=0 in IDLE. The RAM clocks reads whenever WE_n=1 regardless of CS. No stray writes.
//  Latency: Req sampled at edge N; RAM op at N+1; Ack high in cycle after N+2. Throughput: 1 access / 3 cycles.
//  Requester inputs may change after grant without effect. A Req dropped before grant is ignored.
//  Arbiter never aborts a granted access except by reset. Reset in ACCESS forces Ram_WE_n=1 at once.
//   A write is lost if reset precedes the RAM edge. No Ack is issued for an aborted access.
//  Simultaneous A and B: winner alternates every grant. Continuous requests give A,B,A,B... with no starvation.
//  Address/data widths pass through unmodified; no arithmetic.
// TESTING
//  Reset, A read addr 0x0005 (preloaded 0x2A7) -> Ram_CS high 2 cycles, A_Ack pulse 2 cycles after grant, A_RdData=0x2A7.
//  B write 0x155 @0x1234, then B read 0x1234 -> one Ram_WE_n low cycle, B_RdData=0x155, A_Ack stays 0.
//  A and B Req rise same edge after reset -> A served first, then B; B_Ack 3 cycles after A_Ack.
//  Both Req held high 12 cycles with re-requests -> Acks strictly alternate A,B,A,B; none missed.
//  A write in flight, Rst_n low mid-ACCESS -> Ram_WE_n=1 immediately, memory unchanged, no Ack, Busy=0.
//  A holds Req one cycle during A_Ack with B idle -> no second A access (masking); Busy falls.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port synchronous RAM between
// requester A (program fetch) and requester B (data access); one access per 3 cycles.
module ram_arbiter #(
  parameter int ADDRESS_SIZE = 16,
  parameter int DATA_SIZE    = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_req_i,
  input  logic                    a_we_n_i,
  input  logic [ADDRESS_SIZE-1:0] a_addr_i,
  input  logic [DATA_SIZE-1:0]    a_wr_data_i,
  output logic                    a_ack_o,
  output logic [DATA_SIZE-1:0]    a_rd_data_o,
  input  logic                    b_req_i,
  input  logic                    b_we_n_i,
  input  logic [ADDRESS_SIZE-1:0] b_addr_i,
  input  logic [DATA_SIZE-1:0]    b_wr_data_i,
  output logic                    b_ack_o,
  output logic [DATA_SIZE-1:0]    b_rd_data_o,
  output logic [ADDRESS_SIZE-1:0] ram_address_o,
  output logic [DATA_SIZE-1:0]    ram_in_o,
  input  logic [DATA_SIZE-1:0]    ram_out_i,
  output logic                    ram_cs_o,
  output logic                    ram_we_n_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_e;
  typedef enum logic {SIDE_A = 1'b0, SIDE_B = 1'b1} side_e;

  state_e                  state_q, state_d;
  side_e                   ptr_q, grant_q, winner;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0]    wdata_q;
  logic                    we_n_q;
  logic                    a_ack_q, b_ack_q;
  logic [DATA_SIZE-1:0]    a_rdata_q, b_rdata_q;
  logic                    a_elig, b_elig, grant_valid;

  // A requester still holding Req during its own Ack cycle must not be re-granted.
  assign a_elig      = a_req_i & ~a_ack_q;
  assign b_elig      = b_req_i & ~b_ack_q;
  assign grant_valid = (state_q == IDLE) && (a_elig || b_elig);
  assign winner      = (a_elig && b_elig) ? ptr_q : (b_elig ? SIDE_B : SIDE_A);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  // NOTE: defaulting state_d first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM pin outputs; write strobe is confined to ACCESS of a write grant so an
  // async reset mid-access drops it immediately.
  always_comb begin
    ram_cs_o   = 1'b0;
    ram_we_n_o = 1'b1;
    busy_o     = 1'b0;
    unique case (state_q)
      ACCESS: begin
        ram_cs_o   = 1'b1;
        ram_we_n_o = we_n_q;
        busy_o     = 1'b1;
      end
      CAPTURE: begin
        ram_cs_o = 1'b1;
        busy_o   = 1'b1;
      end
      default: ;
    endcase
  end

  // Grant latches, round-robin pointer, acks and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= SIDE_A;
      grant_q   <= SIDE_A;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_n_q    <= 1'b1;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (grant_valid) begin
        grant_q <= winner;
        ptr_q   <= (winner == SIDE_A) ? SIDE_B : SIDE_A;
        addr_q  <= (winner == SIDE_A) ? a_addr_i    : b_addr_i;
        wdata_q <= (winner == SIDE_A) ? a_wr_data_i : b_wr_data_i;
        we_n_q  <= (winner == SIDE_A) ? a_we_n_i    : b_we_n_i;
      end
      a_ack_q <= (state_q == CAPTURE) && (grant_q == SIDE_A);
      b_ack_q <= (state_q == CAPTURE) && (grant_q == SIDE_B);
      if (state_q == CAPTURE && we_n_q) begin
        if (grant_q == SIDE_A) a_rdata_q <= ram_out_i;
        else                   b_rdata_q <= ram_out_i;
      end
    end
  end

  assign ram_address_o = addr_q;
  assign ram_in_o      = wdata_q;
  assign a_ack_o       = a_ack_q;
  assign b_ack_o       = b_ack_q;
  assign a_rd_data_o   = a_rdata_q;
  assign b_rd_data_o   = b_rdata_q;

endmodule
